snes_pad_serializer: RTL and testbench

- Parametrised successor to the single-pad SNES joypad serializer.
- Presents up to four decoded 12-button pad states to the SNES core over the native strobe/clock joypad protocol on two data lines, D0 and D1.
- Adds Super Multitap lane muxing via the IO-select line, per-button turbo, correct post-frame fill bits and poll-status pulses.
- Sits between the controller front-ends (dualshock/USB decoders) and the SNES CPU joypad port.

---
 rtl/snes_pad_pkg.sv | 30 +++
 rtl/snes_pad_lane.sv | 28 ++
 rtl/snes_pad_serializer.sv | 146 ++++++++++++++
 tb/tb_snes_pad_serializer.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snes_pad_pkg.sv
// Shared constants and types for the SNES joypad serializer.
// Button order matches the order the SNES shifts them out.
package snes_pad_pkg;

    localparam int FRAME_BITS = 16;
    localparam int BTN_W      = 12;
    localparam int NLANES     = 4;

    localparam int BTN_B      = 0;
    localparam int BTN_Y      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DN     = 5;
    localparam int BTN_LT     = 6;
    localparam int BTN_RT     = 7;
    localparam int BTN_A      = 8;
    localparam int BTN_X      = 9;
    localparam int BTN_L      = 10;
    localparam int BTN_R      = 11;

    typedef logic [BTN_W-1:0]      btn_t;
    typedef logic [FRAME_BITS-1:0] frame_t;

    // Upper four bits carry the standard-pad ID, which is all zeros.
    function automatic frame_t frame_of(input btn_t b);
        return {{(FRAME_BITS-BTN_W){1'b0}}, b};
    endfunction

endpackage

// File: rtl/snes_pad_lane.sv
// One joypad data lane: 16-bit frame register with 1-fill on shift.
// Load has priority over shift.
module snes_pad_lane
    import snes_pad_pkg::*;
(
    input  logic clk,
    input  logic resetn,
    input  logic load,
    input  logic shift,
    input  btn_t eff,
    output logic bit0
);

    frame_t r_frame;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_frame <= '0;
        end else if (load) begin
            r_frame <= frame_of(eff);
        end else if (shift) begin
            r_frame <= {1'b1, r_frame[FRAME_BITS-1:1]};
        end
    end

    assign bit0 = r_frame[0];

endmodule

// File: rtl/snes_pad_serializer.sv
// Multi-pad SNES joypad serializer with multitap lane muxing,
// per-button turbo, 1-fill after the frame and poll/frame pulses.
module snes_pad_serializer
    import snes_pad_pkg::*;
#(
    parameter int NPADS       = 2,
    parameter int TURBO_DIV   = 180_000,
    parameter int SYNC_STAGES = 0
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   multitap_en,
    input  logic [NPADS*BTN_W-1:0] pad_buttons,
    input  logic [NPADS*BTN_W-1:0] turbo_mask,
    input  logic                   joy_strb,
    input  logic                   joy_clk,
    input  logic                   joy_iosel,
    output logic [1:0]             joy_di,
    output logic                   poll_pulse,
    output logic                   frame_done
);

    localparam int TW = (TURBO_DIV > 1) ? $clog2(TURBO_DIV) : 1;

    logic w_strb;
    logic w_clk;
    logic w_iosel;

    generate
        if (SYNC_STAGES == 2) begin : g_sync
            logic [2:0] r_s1;
            logic [2:0] r_s2;
            always_ff @(posedge clk) begin
                if (!resetn) begin
                    r_s1 <= 3'b110;
                    r_s2 <= 3'b110;
                end else begin
                    r_s1 <= {joy_clk, joy_iosel, joy_strb};
                    r_s2 <= r_s1;
                end
            end
            assign {w_clk, w_iosel, w_strb} = r_s2;
        end else begin : g_nosync
            assign {w_clk, w_iosel, w_strb} = {joy_clk, joy_iosel, joy_strb};
        end
    endgenerate

    logic          r_clk_q;
    logic          r_strb_q;
    logic          r_hold;
    logic          r_mtap;
    logic          r_phase;
    logic [TW-1:0] r_tcnt;
    logic [4:0]    r_bit_cnt;
    logic          r_poll;
    logic          r_done;

    logic w_load;
    logic w_shift;

    assign w_load  = w_strb;
    assign w_shift = r_clk_q & ~w_clk & ~w_strb;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_clk_q   <= 1'b1;
            r_strb_q  <= 1'b0;
            r_hold    <= 1'b1;
            r_mtap    <= 1'b0;
            r_phase   <= 1'b0;
            r_tcnt    <= '0;
            r_bit_cnt <= '0;
            r_poll    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_clk_q  <= w_clk;
            r_strb_q <= w_strb;
            r_hold   <= 1'b0;
            r_mtap   <= multitap_en;
            r_poll   <= r_strb_q & ~w_strb;
            r_done   <= 1'b0;
            if (r_tcnt == TW'(TURBO_DIV - 1)) begin
                r_tcnt  <= '0;
                r_phase <= ~r_phase;
            end else begin
                r_tcnt <= r_tcnt + 1'b1;
            end
            if (w_load) begin
                r_bit_cnt <= '0;
            end else if (w_shift && r_bit_cnt != 5'd16) begin
                r_bit_cnt <= r_bit_cnt + 5'd1;
                r_done    <= (r_bit_cnt == 5'd15);
            end
        end
    end

    btn_t       w_eff [NLANES];
    logic [3:0] w_bit;

    // Pads beyond NPADS are tied to released.
    generate
        for (genvar p = 0; p < NLANES; p++) begin : g_lane
            if (p < NPADS) begin : g_used
                assign w_eff[p] = pad_buttons[p*BTN_W +: BTN_W]
                                & ~(turbo_mask[p*BTN_W +: BTN_W]
                                    & {BTN_W{r_phase}});
            end else begin : g_unused
                assign w_eff[p] = '0;
            end
            snes_pad_lane u_lane (
                .clk    (clk),
                .resetn (resetn),
                .load   (w_load),
                .shift  (w_shift),
                .eff    (w_eff[p]),
                .bit0   (w_bit[p])
            );
        end
    endgenerate

    logic [1:0] w_di;

    always_comb begin
        w_di = 2'b11;
        if (!resetn || r_hold) begin
            w_di = 2'b11;
        end else begin
            if (!r_mtap) begin
                w_di = {1'b1, ~w_bit[0]};
            end else if (w_iosel) begin
                w_di = {~w_bit[1], ~w_bit[0]};
            end else begin
                w_di = {~w_bit[3], ~w_bit[2]};
            end
            // Multitap signature: D1 reads as 1 while strobed.
            if (r_mtap && w_strb) begin
                w_di[1] = 1'b0;
            end
        end
    end

    assign joy_di     = w_di;
    assign poll_pulse = r_poll;
    assign frame_done = r_done;

endmodule

// File: tb/tb_snes_pad_serializer.sv
// Self-checking bench for snes_pad_serializer with a frame-level
// reference model (button word -> 16-bit frame with 1-fill).
module tb_snes_pad_serializer;
    import snes_pad_pkg::*;

    localparam int NP = 4;
    localparam int TD = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             resetn;
    logic             multitap_en;
    logic [NP*12-1:0] pad_buttons;
    logic [NP*12-1:0] turbo_mask;
    logic             joy_strb;
    logic             joy_clk;
    logic             joy_iosel;
    logic [1:0]       joy_di;
    logic             poll_pulse;
    logic             frame_done;
    logic [1:0]       joy_di1;
    logic             poll_pulse1;
    logic             frame_done1;

    int checks   = 0;
    int failures = 0;
    int tb_cyc;
    btn_t m_eff [4];
    int m_k;

    snes_pad_serializer #(
        .NPADS(NP), .TURBO_DIV(TD), .SYNC_STAGES(0)
    ) u_dut (
        .clk         (clk),
        .resetn      (resetn),
        .multitap_en (multitap_en),
        .pad_buttons (pad_buttons),
        .turbo_mask  (turbo_mask),
        .joy_strb    (joy_strb),
        .joy_clk     (joy_clk),
        .joy_iosel   (joy_iosel),
        .joy_di      (joy_di),
        .poll_pulse  (poll_pulse),
        .frame_done  (frame_done)
    );

    snes_pad_serializer #(
        .NPADS(1), .TURBO_DIV(TD), .SYNC_STAGES(0)
    ) u_dut1 (
        .clk         (clk),
        .resetn      (resetn),
        .multitap_en (multitap_en),
        .pad_buttons (pad_buttons[11:0]),
        .turbo_mask  (turbo_mask[11:0]),
        .joy_strb    (joy_strb),
        .joy_clk     (joy_clk),
        .joy_iosel   (joy_iosel),
        .joy_di      (joy_di1),
        .poll_pulse  (poll_pulse1),
        .frame_done  (frame_done1)
    );

    // Non-reset cycles since reset; turbo phase = (cycle / TD) mod 2.
    always @(posedge clk) begin
        if (!resetn) tb_cyc <= 0;
        else tb_cyc <= tb_cyc + 1;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic btn_t pad_of(input logic [NP*12-1:0] v, input int p);
        return v[p*12 +: 12];
    endfunction

    // Wire level of a lane after k shifts (low = pressed).
    function automatic logic lane_wire(input btn_t e, input int k);
        logic [15:0] f;
        f = {4'b0000, e};
        if (k >= 16) return 1'b0;
        return ~f[k];
    endfunction

    function automatic logic [1:0] exp_di(input logic mt, input logic io,
                                          input logic st, input int k);
        logic [1:0] d;
        if (!mt) d = {1'b1, lane_wire(m_eff[0], k)};
        else if (io) d = {lane_wire(m_eff[1], k), lane_wire(m_eff[0], k)};
        else d = {lane_wire(m_eff[3], k), lane_wire(m_eff[2], k)};
        if (mt && st) d[1] = 1'b0;
        return d;
    endfunction

    task automatic strobe(input int hold);
        int ph;
        joy_strb = 1'b1;
        repeat (hold) tick();
        ph = ((tb_cyc - 1) / TD) % 2;
        for (int p = 0; p < 4; p++)
            m_eff[p] = pad_of(pad_buttons, p)
                     & ~(pad_of(turbo_mask, p) & {12{ph[0]}});
        m_k = 0;
    endtask

    task automatic unstrobe;
        joy_strb = 1'b0;
        tick();
    endtask

    task automatic shift_fall;
        joy_clk = 1'b0;
        tick();
        m_k++;
    endtask

    task automatic shift_rise;
        joy_clk = 1'b1;
        tick();
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        multitap_en = 1'b0;
        joy_strb = 1'b0;
        joy_clk = 1'b1;
        joy_iosel = 1'b1;
        pad_buttons = '0;
        turbo_mask = '0;
        repeat (3) tick();
        checks++;
        if (joy_di !== 2'b11) begin
            failures++;
            $display("FAIL reset_di got=%b exp=11", joy_di);
        end
        checks++;
        if (poll_pulse !== 1'b0 || frame_done !== 1'b0) begin
            failures++;
            $display("FAIL reset_pulses got=%b%b exp=00", poll_pulse, frame_done);
        end
        resetn = 1'b1;
        #1;
        checks++;
        if (joy_di !== 2'b11) begin
            failures++;
            $display("FAIL reset_after_di got=%b exp=11", joy_di);
        end
        tick();
        checks++;
        if (joy_di !== 2'b11 || frame_done !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle got=%b/%b exp=11/0", joy_di, frame_done);
        end
    endtask

    task automatic test_single_b;
        int ndone;
        logic d0;
        ndone = 0;
        multitap_en = 1'b0;
        pad_buttons = {$urandom, $urandom};
        pad_buttons[11:0] = 12'h001;
        turbo_mask = '0;
        tick();
        strobe(2);
        checks++;
        if (joy_di !== 2'b10) begin
            failures++;
            $display("FAIL single_strobe got=%b exp=10", joy_di);
        end
        unstrobe();
        checks++;
        if (poll_pulse !== 1'b1) begin
            failures++;
            $display("FAIL single_poll got=%b exp=1", poll_pulse);
        end
        for (int k = 0; k < 20; k++) begin
            d0 = (k == 0 || k >= 16) ? 1'b0 : 1'b1;
            checks++;
            if (joy_di !== {1'b1, d0}) begin
                failures++;
                $display("FAIL single_read%0d got=%b exp=%b", k, joy_di, {1'b1, d0});
            end
            shift_fall();
            if (frame_done === 1'b1) ndone++;
            checks++;
            if (frame_done !== (m_k == 16)) begin
                failures++;
                $display("FAIL single_done shift%0d got=%b exp=%b", m_k, frame_done, m_k == 16);
            end
            shift_rise();
        end
        checks++;
        if (ndone != 1) begin
            failures++;
            $display("FAIL single_done_count got=%0d exp=1", ndone);
        end
    endtask

    task automatic test_multitap;
        logic [1:0] e;
        multitap_en = 1'b1;
        pad_buttons = {12'h010, 12'h800, 12'h002, 12'h001};
        turbo_mask = '0;
        for (int pass = 0; pass < 2; pass++) begin
            joy_iosel = (pass == 0);
            tick();
            strobe(1);
            unstrobe();
            for (int k = 0; k < 16; k++) begin
                if (pass == 0) e = {k != 1, k != 0};
                else e = {k != 4, k != 11};
                checks++;
                if (joy_di !== e) begin
                    failures++;
                    $display("FAIL mtap_io%0d_bit%0d got=%b exp=%b", joy_iosel, k, joy_di, e);
                end
                if (pass == 0) begin
                    checks++;
                    if (joy_di1 !== {1'b1, k != 0}) begin
                        failures++;
                        $display("FAIL mtap_npads1_bit%0d got=%b exp=%b", k, joy_di1, {1'b1, k != 0});
                    end
                end
                shift_fall();
                shift_rise();
            end
        end
    endtask

    task automatic test_signature;
        joy_iosel = 1'b1;
        pad_buttons = '0;
        multitap_en = 1'b1;
        tick();
        strobe(1);
        checks++;
        if (joy_di[1] !== 1'b0) begin
            failures++;
            $display("FAIL sig_mtap d1 got=%b exp=0", joy_di[1]);
        end
        unstrobe();
        multitap_en = 1'b0;
        tick();
        strobe(1);
        checks++;
        if (joy_di[1] !== 1'b1) begin
            failures++;
            $display("FAIL sig_single d1 got=%b exp=1", joy_di[1]);
        end
        unstrobe();
    endtask

    task automatic test_turbo;
        logic prev;
        logic cur;
        multitap_en = 1'b0;
        pad_buttons = '0;
        pad_buttons[11:0] = 12'h001;
        turbo_mask = '0;
        turbo_mask[11:0] = 12'h001;
        prev = 1'b0;
        tick();
        for (int i = 0; i < 8; i++) begin
            strobe(1);
            cur = joy_di[0];
            checks++;
            if (cur !== lane_wire(m_eff[0], 0)) begin
                failures++;
                $display("FAIL turbo_poll%0d got=%b exp=%b", i, cur, lane_wire(m_eff[0], 0));
            end
            if (i > 0) begin
                checks++;
                if (cur === prev) begin
                    failures++;
                    $display("FAIL turbo_alt%0d got=%b exp=%b", i, cur, ~prev);
                end
            end
            prev = cur;
            unstrobe();
            repeat (2) tick();
        end
        turbo_mask = '0;
    endtask

    task automatic test_coincident;
        int ndone;
        ndone = 0;
        multitap_en = 1'b0;
        pad_buttons = {$urandom, $urandom};
        turbo_mask = '0;
        tick();
        strobe(1);
        joy_clk = 1'b0;
        tick();
        joy_clk = 1'b1;
        tick();
        unstrobe();
        for (int k = 0; k < 17; k++) begin
            checks++;
            if (joy_di !== exp_di(1'b0, joy_iosel, 1'b0, m_k)) begin
                failures++;
                $display("FAIL coinc_bit%0d got=%b exp=%b", k, joy_di, exp_di(1'b0, joy_iosel, 1'b0, m_k));
            end
            shift_fall();
            if (frame_done === 1'b1) begin
                ndone++;
                checks++;
                if (m_k != 16) begin
                    failures++;
                    $display("FAIL coinc_done_at got=%0d exp=16", m_k);
                end
            end
            shift_rise();
        end
        checks++;
        if (ndone != 1) begin
            failures++;
            $display("FAIL coinc_done_count got=%0d exp=1", ndone);
        end
    endtask

    task automatic test_reset_midframe;
        int ndone;
        ndone = 0;
        multitap_en = 1'b1;
        joy_iosel = 1'b1;
        pad_buttons = {$urandom, $urandom};
        tick();
        strobe(1);
        unstrobe();
        repeat (5) begin
            shift_fall();
            shift_rise();
        end
        resetn = 1'b0;
        tick();
        checks++;
        if (joy_di !== 2'b11) begin
            failures++;
            $display("FAIL midrst_di got=%b exp=11", joy_di);
        end
        resetn = 1'b1;
        #1;
        checks++;
        if (joy_di !== 2'b11) begin
            failures++;
            $display("FAIL midrst_after got=%b exp=11", joy_di);
        end
        tick();
        checks++;
        if (joy_di !== 2'b11) begin
            failures++;
            $display("FAIL midrst_cleared got=%b exp=11", joy_di);
        end
        strobe(1);
        unstrobe();
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (joy_di !== exp_di(1'b1, 1'b1, 1'b0, m_k)) begin
                failures++;
                $display("FAIL midrst_bit%0d got=%b exp=%b", k, joy_di, exp_di(1'b1, 1'b1, 1'b0, m_k));
            end
            shift_fall();
            if (frame_done === 1'b1) ndone++;
            shift_rise();
        end
        checks++;
        if (ndone != 1) begin
            failures++;
            $display("FAIL midrst_done_count got=%0d exp=1", ndone);
        end
    endtask

    task automatic test_random;
        logic mt;
        for (int it = 0; it < 6; it++) begin
            mt = $urandom_range(0, 1);
            multitap_en = mt;
            pad_buttons = {$urandom, $urandom};
            turbo_mask = {$urandom, $urandom};
            joy_iosel = $urandom_range(0, 1);
            tick();
            strobe($urandom_range(1, 5));
            checks++;
            if (joy_di !== exp_di(mt, joy_iosel, 1'b1, 0)) begin
                failures++;
                $display("FAIL rnd%0d_strobe got=%b exp=%b", it, joy_di, exp_di(mt, joy_iosel, 1'b1, 0));
            end
            unstrobe();
            checks++;
            if (poll_pulse !== 1'b1) begin
                failures++;
                $display("FAIL rnd%0d_poll got=%b exp=1", it, poll_pulse);
            end
            for (int k = 0; k < 18; k++) begin
                checks++;
                if (joy_di !== exp_di(mt, joy_iosel, 1'b0, m_k)) begin
                    failures++;
                    $display("FAIL rnd%0d_bit%0d got=%b exp=%b", it, m_k, joy_di, exp_di(mt, joy_iosel, 1'b0, m_k));
                end
                joy_iosel = $urandom_range(0, 1);
                shift_fall();
                checks++;
                if (frame_done !== (m_k == 16) || poll_pulse !== 1'b0) begin
                    failures++;
                    $display("FAIL rnd%0d_pulses shift%0d got=%b%b exp=0%b", it, m_k, poll_pulse, frame_done, m_k == 16);
                end
                shift_rise();
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_b();
        test_multitap();
        test_signature();
        test_turbo();
        test_coincident();
        test_reset_midframe();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
